// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD timer with a one-second prescaler and up/down counting.
// It can run, pause and resume, and flags expiry when the count reaches its end value.
module bcd_countdown_timer #(
    parameter  int MIN_DIGITS = 2,
    parameter  int TICK_DIV   = 50000000,
    localparam int TW         = 4 * (MIN_DIGITS + 2)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [TW-1:0] load_value,
    input  logic          start,
    input  logic          stop,
    input  logic          dir,
    output logic [TW-1:0] time_out,
    output logic          running,
    output logic          expired,
    output logic          done_pulse,
    output logic          load_err
);

    localparam int ND = MIN_DIGITS + 2;
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_EXP
    } state_e;

    // Digit 1 is seconds-tens (0-5); every other digit is 0-9.
    function automatic logic [3:0] dig_max(input int i);
        return (i == 1) ? 4'd5 : 4'd9;
    endfunction

    function automatic logic [TW-1:0] max_time();
        logic [TW-1:0] m;
        m = '0;
        for (int i = 0; i < ND; i++) begin
            m[4*i +: 4] = dig_max(i);
        end
        return m;
    endfunction

    function automatic logic is_valid(input logic [TW-1:0] t);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < ND; i++) begin
            if (t[4*i +: 4] > dig_max(i)) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    function automatic logic [TW-1:0] step(input logic [TW-1:0] t,
                                           input logic up);
        logic [TW-1:0] r;
        logic [3:0]    d;
        logic          c;
        r = t;
        c = 1'b1;
        for (int i = 0; i < ND; i++) begin
            d = t[4*i +: 4];
            if (c) begin
                if (up) begin
                    c = (d == dig_max(i));
                    d = c ? 4'd0 : d + 4'd1;
                end else begin
                    c = (d == 4'd0);
                    d = c ? dig_max(i) : d - 4'd1;
                end
            end
            r[4*i +: 4] = d;
        end
        return r;
    endfunction

    localparam logic [TW-1:0] TMAX = max_time();

    state_e        state_q, state_d;
    logic [TW-1:0] time_q, time_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          dir_q, dir_d;
    logic          done_q, done_d;
    logic          lerr_q, lerr_d;

    logic          tick;
    logic          start_ok;
    logic [TW-1:0] nxt;
    logic [TW-1:0] bound;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            time_q  <= '0;
            presc_q <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
            lerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            presc_q <= presc_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
            lerr_q  <= lerr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        time_d   = time_q;
        presc_d  = presc_q;
        dir_d    = dir_q;
        done_d   = 1'b0;
        lerr_d   = 1'b0;
        tick     = (state_q == S_RUN) && (presc_q == LAST);
        nxt      = step(time_q, dir_q);
        bound    = dir_q ? TMAX : '0;
        // A start aimed at a boundary already reached is refused.
        start_ok = start && (time_q != (dir ? TMAX : '0));

        if (load) begin
            if (is_valid(load_value)) begin
                time_d  = load_value;
                state_d = S_IDLE;
                presc_d = '0;
            end else begin
                lerr_d = 1'b1;
            end
        end else if (stop) begin
            if (state_q == S_RUN) begin
                state_d = S_PAUSE;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        dir_d   = dir;
                        state_d = S_RUN;
                        presc_d = '0;
                    end
                end
                S_PAUSE: begin
                    if (start_ok) begin
                        dir_d   = dir;
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (tick) begin
                        presc_d = '0;
                        time_d  = nxt;
                        if (nxt == bound) begin
                            state_d = S_EXP;
                            done_d  = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign time_out   = time_q;
    assign running    = (state_q == S_RUN);
    assign expired    = (state_q == S_EXP);
    assign done_pulse = done_q;
    assign load_err   = lerr_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer with TICK_DIV=4 and MIN_DIGITS=2.
module tb_bcd_countdown_timer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_value = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        dir = 1'b0;
    logic [15:0] time_out;
    logic        running;
    logic        expired;
    logic        done_pulse;
    logic        load_err;

    int ncmp = 0;
    int nerr = 0;

    bcd_countdown_timer #(
        .MIN_DIGITS(2),
        .TICK_DIV(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .load(load),
        .load_value(load_value),
        .start(start),
        .stop(stop),
        .dir(dir),
        .time_out(time_out),
        .running(running),
        .expired(expired),
        .done_pulse(done_pulse),
        .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1;
        load_value = v;
        cyc();
        load = 1'b0;
    endtask

    task automatic do_start(input logic d);
        start = 1'b1;
        dir = d;
        cyc();
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        ncmp++;
        if ({time_out, running, expired, done_pulse, load_err} !== 20'h0) begin
            nerr++;
            $display("FAIL reset: got %h/%b%b%b%b want 0000/0000",
                     time_out, running, expired, done_pulse, load_err);
        end
    endtask

    task automatic test_down;
        do_load(16'h0003);
        do_start(1'b0);
        ncmp++;
        if (running !== 1'b1) begin
            nerr++;
            $display("FAIL down_run: got %b want 1", running);
        end
        cyc(3);
        ncmp++;
        if (time_out !== 16'h0003) begin
            nerr++;
            $display("FAIL down_c3: got %h want 0003", time_out);
        end
        cyc();
        ncmp++;
        if (time_out !== 16'h0002) begin
            nerr++;
            $display("FAIL down_c4: got %h want 0002", time_out);
        end
        cyc(4);
        ncmp++;
        if (time_out !== 16'h0001) begin
            nerr++;
            $display("FAIL down_c8: got %h want 0001", time_out);
        end
        cyc(3);
        ncmp++;
        if (done_pulse !== 1'b0 || expired !== 1'b0) begin
            nerr++;
            $display("FAIL down_c11: got done=%b exp=%b want 0 0",
                     done_pulse, expired);
        end
        cyc();
        ncmp++;
        if ({time_out, done_pulse, expired, running} !== {16'h0000, 3'b110}) begin
            nerr++;
            $display("FAIL down_c12: got %h d%b e%b r%b want 0000 d1 e1 r0",
                     time_out, done_pulse, expired, running);
        end
        cyc();
        ncmp++;
        if ({time_out, done_pulse, expired} !== {16'h0000, 2'b01}) begin
            nerr++;
            $display("FAIL down_c13: got %h d%b e%b want 0000 d0 e1",
                     time_out, done_pulse, expired);
        end
    endtask

    task automatic test_borrow;
        do_load(16'h1000);
        ncmp++;
        if (expired !== 1'b0 || time_out !== 16'h1000) begin
            nerr++;
            $display("FAIL borrow_load: got %h e%b want 1000 e0",
                     time_out, expired);
        end
        do_start(1'b0);
        cyc(4);
        ncmp++;
        if (time_out !== 16'h0959) begin
            nerr++;
            $display("FAIL borrow_1000: got %h want 0959", time_out);
        end
        do_load(16'h0100);
        do_start(1'b0);
        cyc(4);
        ncmp++;
        if (time_out !== 16'h0059) begin
            nerr++;
            $display("FAIL borrow_0100: got %h want 0059", time_out);
        end
    endtask

    task automatic test_up;
        do_load(16'h0959);
        do_start(1'b1);
        cyc(4);
        ncmp++;
        if (time_out !== 16'h1000 || done_pulse !== 1'b0) begin
            nerr++;
            $display("FAIL up_carry: got %h d%b want 1000 d0",
                     time_out, done_pulse);
        end
        do_load(16'h9958);
        do_start(1'b1);
        cyc(4);
        ncmp++;
        if ({time_out, done_pulse, expired, running} !== {16'h9959, 3'b110}) begin
            nerr++;
            $display("FAIL up_max: got %h d%b e%b r%b want 9959 d1 e1 r0",
                     time_out, done_pulse, expired, running);
        end
        do_start(1'b1);
        cyc(5);
        ncmp++;
        if ({time_out, done_pulse, expired, running} !== {16'h9959, 3'b010}) begin
            nerr++;
            $display("FAIL up_hold: got %h d%b e%b r%b want 9959 d0 e1 r0",
                     time_out, done_pulse, expired, running);
        end
        do_start(1'b0);
        cyc(5);
        ncmp++;
        if ({time_out, expired, running} !== {16'h9959, 2'b10}) begin
            nerr++;
            $display("FAIL up_hold_dn: got %h e%b r%b want 9959 e1 r0",
                     time_out, expired, running);
        end
    endtask

    task automatic test_pause;
        do_load(16'h0005);
        do_start(1'b0);
        cyc(2);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ncmp++;
            if (time_out !== 16'h0005 || running !== 1'b0) begin
                nerr++;
                $display("FAIL pause_hold%0d: got %h r%b want 0005 r0",
                         i, time_out, running);
            end
            cyc();
        end
        do_start(1'b0);
        cyc();
        ncmp++;
        if (time_out !== 16'h0005 || running !== 1'b1) begin
            nerr++;
            $display("FAIL resume_c1: got %h r%b want 0005 r1",
                     time_out, running);
        end
        cyc();
        ncmp++;
        if (time_out !== 16'h0004) begin
            nerr++;
            $display("FAIL resume_c2: got %h want 0004", time_out);
        end
        start = 1'b1;
        stop = 1'b1;
        cyc();
        start = 1'b0;
        stop = 1'b0;
        cyc(6);
        ncmp++;
        if ({time_out, running, expired} !== {16'h0004, 2'b00}) begin
            nerr++;
            $display("FAIL start_stop: got %h r%b e%b want 0004 r0 e0",
                     time_out, running, expired);
        end
    endtask

    task automatic test_invalid;
        do_load(16'h0042);
        do_load(16'h0060);
        ncmp++;
        if (load_err !== 1'b1 || time_out !== 16'h0042) begin
            nerr++;
            $display("FAIL bad_0060: got err%b %h want err1 0042",
                     load_err, time_out);
        end
        cyc();
        ncmp++;
        if (load_err !== 1'b0) begin
            nerr++;
            $display("FAIL err_pulse: got %b want 0", load_err);
        end
        do_load(16'h00A0);
        ncmp++;
        if (load_err !== 1'b1 || time_out !== 16'h0042) begin
            nerr++;
            $display("FAIL bad_00A0: got err%b %h want err1 0042",
                     load_err, time_out);
        end
        do_load(16'h0A00);
        ncmp++;
        if (load_err !== 1'b1 || time_out !== 16'h0042) begin
            nerr++;
            $display("FAIL bad_0A00: got err%b %h want err1 0042",
                     load_err, time_out);
        end
        do_load(16'h0000);
        ncmp++;
        if (load_err !== 1'b0) begin
            nerr++;
            $display("FAIL good_load: got err%b want 0", load_err);
        end
        do_start(1'b0);
        cyc(5);
        ncmp++;
        if ({running, expired, done_pulse} !== 3'b000) begin
            nerr++;
            $display("FAIL zero_start: got r%b e%b d%b want 000",
                     running, expired, done_pulse);
        end
    endtask

    task automatic test_load_mid_run;
        do_load(16'h0010);
        do_start(1'b0);
        cyc(2);
        do_load(16'h0500);
        ncmp++;
        if (time_out !== 16'h0500 || running !== 1'b0) begin
            nerr++;
            $display("FAIL mid_load: got %h r%b want 0500 r0",
                     time_out, running);
        end
        do_start(1'b0);
        cyc(3);
        ncmp++;
        if (time_out !== 16'h0500) begin
            nerr++;
            $display("FAIL mid_c3: got %h want 0500", time_out);
        end
        cyc();
        ncmp++;
        if (time_out !== 16'h0459) begin
            nerr++;
            $display("FAIL mid_c4: got %h want 0459", time_out);
        end
    endtask

    task automatic test_reset_mid_run;
        do_load(16'h0001);
        do_start(1'b0);
        cyc(3);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        ncmp++;
        if ({time_out, running, expired, done_pulse, load_err} !== 20'h0) begin
            nerr++;
            $display("FAIL mid_reset: got %h/%b%b%b%b want 0000/0000",
                     time_out, running, expired, done_pulse, load_err);
        end
        cyc(6);
        ncmp++;
        if ({running, expired, done_pulse} !== 3'b000) begin
            nerr++;
            $display("FAIL post_reset: got r%b e%b d%b want 000",
                     running, expired, done_pulse);
        end
    endtask

    initial begin
        test_reset();
        test_down();
        test_borrow();
        test_up();
        test_pause();
        test_invalid();
        test_load_mid_run();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Parametrised MM:SS BCD timer with an internal seconds prescaler, selectable count direction, and run/pause/expire control.
- Sits between the keypad/load logic (load value) and the 7-segment display driver (digit outputs) in the egg-timer datapath.
- Raises a one-cycle done pulse and a sticky expired flag for the alarm block.

Parameters:
MIN_DIGITS, 2, number of BCD minute digits (1..4); seconds are always 2 digits (ones 0-9, tens 0-5).
TICK_DIV, 50000000, clk cycles per one-second tick (>=2).
TW, 4*(MIN_DIGITS+2), derived total time width; not overridden.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
load  in  1  load load_value, return to IDLE
load_value  in  TW  BCD time; [3:0] sec ones, [7:4] sec tens, then minute digits ascending
start  in  1  begin or resume counting
stop  in  1  pause counting
dir  in  1  0 = count down to zero, 1 = count up to maximum; sampled only when a start is accepted
time_out  out  TW  current BCD time, same packing as load_value
running  out  1  high in RUN
expired  out  1  sticky; high in EXPIRED
done_pulse  out  1  one-cycle pulse on entry to EXPIRED
load_err  out  1  one-cycle pulse when a load is rejected

Behaviour:
- Reset: time_out = 0, state IDLE, prescaler = 0, dir latch = 0; running, expired, done_pulse and load_err = 0.
- States: IDLE, RUN, PAUSE, EXPIRED.
- Command priority per cycle: reset > load > stop > start. If start and stop are high together, stop wins.

Load (any state):
- Valid load_value: time_out <= load_value, state <= IDLE, prescaler cleared, expired cleared.
- Invalid BCD (any digit >9, or sec tens >5): load rejected. load_err = 1 the next cycle; time, state and prescaler are unchanged.

Start:
- Accepted only in IDLE and PAUSE.
- Latches dir, state <= RUN.
- From IDLE, the prescaler restarts at 0. From PAUSE, it resumes from its held value.
- Rejected and ignored if the target boundary is already reached: time = 0 with dir = 0, or time = max with dir = 1. Max is all minute digits 9 and 59 seconds.
- Start in RUN or EXPIRED is ignored.

Stop:
- In RUN: state <= PAUSE, prescaler held, time held.
- In any other state: ignored.

Prescaler and tick:
- In RUN the prescaler counts 0..TICK_DIV-1 and wraps.
- tick = (prescaler == TICK_DIV-1) && RUN.
- The first time step occurs exactly TICK_DIV cycles after the start edge (fresh start).

Time step on tick (registered, visible the cycle after tick):
- Down: sec ones decrements. 0 -> 9 with borrow to sec tens. Sec tens 0 -> 5 with borrow to min ones. Each minute digit 0 -> 9 with borrow to the next digit.
- Up: symmetric. Sec ones 9 -> 0 carries; sec tens 5 -> 0 carries; minute digits 9 -> 0 carry.
- The value never wraps past the boundary. A step that produces the boundary value (0 down, max up) moves state to EXPIRED in the same edge.
- done_pulse is asserted the cycle the boundary value first appears on time_out.

EXPIRED:
- time_out holds the boundary value; expired = 1.
- Only load or reset leaves this state.

Outputs:
- All outputs are registered; no combinational paths from inputs to outputs.

Reset mid-count:
- Clears everything on the next edge; no done_pulse is generated.

Test Plan:
- TICK_DIV=4, MIN_DIGITS=2: load 0x0003, start with dir=0 -> time 0002 at cycle 4 after start, 0001 at 8, 0000 at 12 with done_pulse=1 that cycle, then expired=1 and running=0.
- Borrow chain: load 0x1000, start dir=0 -> after one tick time_out = 0x0959; load 0x0100 -> 0x0059.
- Up mode: load 0x9958, start dir=1 -> 0x9959 after one tick with done_pulse, EXPIRED; a further start is ignored and the value is held.
- Pause/resume: start, stop at cycle 2 -> running=0 and the value is held for 10 cycles; start again -> next step 2 cycles after resume. Simultaneous start+stop in RUN -> PAUSE.
- Invalid load: load 0x0060 or 0x00A0 -> load_err pulse, time and state unchanged. Start with time 0x0000 and dir=0 -> stays IDLE, no done_pulse.
- Load mid-run and reset mid-run: load 0x0500 during RUN -> IDLE with 0x0500 and prescaler cleared. Reset during RUN -> all outputs 0 next cycle, no done_pulse.
